// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM states and commit kinds for the E-stage multiply/divide unit.
// Optional accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MFHI     = 4'd5,
        MFLO     = 4'd6,
        MTHI     = 4'd7,
        MTLO     = 4'd8,
        MADD     = 4'd9,
        MADDU    = 4'd10,
        MSUB     = 4'd11,
        MSUBU    = 4'd12
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // How the latched result reaches HI/LO when the busy window closes.
    typedef enum logic [1:0] {
        COMMIT_SET  = 2'd0,
        COMMIT_SKIP = 2'd1,
        COMMIT_ADD  = 2'd2,
        COMMIT_SUB  = 2'd3
    } mdu_commit_e;

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational MDU datapath: 64-bit products and 32-bit quotient/remainder pairs.
// Returns {hi,lo} for the selected op plus a divide-by-zero flag.
module mdu_ctrl_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        divZero_o
);

    logic signed [63:0] sProd;
    logic        [63:0] uProd;
    logic signed [31:0] sQuot;
    logic signed [31:0] sRem;
    logic        [31:0] uQuot;
    logic        [31:0] uRem;

    always_comb begin
        sProd = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        uProd = {32'd0, a_i} * {32'd0, b_i};
        divZero_o = (b_i == 32'd0);
        sQuot = '0;
        sRem  = '0;
        uQuot = '0;
        uRem  = '0;
        if (!divZero_o) begin
            uQuot = a_i / b_i;
            uRem  = a_i % b_i;
            // The one overflowing signed quotient is pinned so it never depends on the tool.
            if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                sQuot = 32'sh8000_0000;
                sRem  = '0;
            end else begin
                sQuot = $signed(a_i) / $signed(b_i);
                sRem  = $signed(a_i) % $signed(b_i);
            end
        end
        case (mdu_op_e'(op_i))
            MULT, MADD, MSUB:    res_o = sProd;
            MULTU, MADDU, MSUBU: res_o = uProd;
            DIV:                 res_o = {sRem, sQuot};
            DIVU:                res_o = {uRem, uQuot};
            default:             res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: fixed-latency busy window, then commit of the latched result to HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

    mdu_state_e  state_q, state_d;
    mdu_commit_e commit_q, commit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   tmp_q, tmp_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   calcRes;
    logic          calcDivZero;

    mdu_ctrl_calc u_calc (
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .res_o     (calcRes),
        .divZero_o (calcDivZero)
    );

    always_comb begin
        state_d  = state_q;
        commit_d = commit_q;
        cnt_d    = cnt_q;
        tmp_d    = tmp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mdu_op_e'(op))
                        MULT, MULTU: begin
                            state_d  = RUN;
                            cnt_d    = MULT_CNT;
                            tmp_d    = calcRes;
                            commit_d = COMMIT_SET;
                        end
                        DIV, DIVU: begin
                            state_d  = RUN;
                            cnt_d    = DIV_CNT;
                            tmp_d    = calcRes;
                            commit_d = calcDivZero ? COMMIT_SKIP : COMMIT_SET;
                        end
                        MTHI: hi_d = a;
                        MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        MADD, MADDU, MSUB, MSUBU: begin
                            state_d  = RUN;
                            cnt_d    = MULT_CNT;
                            tmp_d    = calcRes;
                            commit_d = (mdu_op_e'(op) == MSUB || mdu_op_e'(op) == MSUBU)
                                       ? COMMIT_SUB : COMMIT_ADD;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Accumulate ops use {HI,LO} as it stands at commit, not at start.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    case (commit_q)
                        COMMIT_SET: {hi_d, lo_d} = tmp_q;
`ifdef MDU_MADD_EN
                        COMMIT_ADD: {hi_d, lo_d} = {hi_q, lo_q} + tmp_q;
                        COMMIT_SUB: {hi_d, lo_d} = {hi_q, lo_q} - tmp_q;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            commit_q <= COMMIT_SET;
            cnt_q    <= '0;
            tmp_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
            tmp_q    <= tmp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
